// File: rtl/dpm_pkg.sv
// Shared sizing constants and types for the 16 x 32 dual-port RAM.
// Imported by the memory top and its read-bypass helper.
package dpm_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/dpm_bypass.sv
// Same-address write-through select for the registered read port.
// A read colliding with a write on the same edge returns the new data.
module dpm_bypass
  import dpm_pkg::*;
(
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  addr_t rd_addr,
  input  word_t mem_data,
  output word_t rd_data
);

  logic hit;

  always_comb begin
    hit     = wr_en && (wr_addr == rd_addr);
    rd_data = hit ? wr_data : mem_data;
  end

endmodule

// File: rtl/dual_port_memory.sv
// 16 x 32 simple dual-port RAM: one write port, one registered read port.
// Flop array with async clear, so it stays out of block RAM.
module dual_port_memory
  import dpm_pkg::*;
(
  input  logic  Clk,
  input  logic  Rst,
  input  logic  Wr_en,
  input  addr_t Wr_addr,
  input  word_t Data_in,
  input  logic  Rd_en,
  input  addr_t Rd_addr,
  output word_t Data_out
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];
  word_t dout_q;
  word_t dout_d;
  word_t rd_data;

  dpm_bypass u_bypass (
    .wr_en    (Wr_en),
    .wr_addr  (Wr_addr),
    .wr_data  (Data_in),
    .rd_addr  (Rd_addr),
    .mem_data (mem_q[Rd_addr]),
    .rd_data  (rd_data)
  );

  always_comb begin
    mem_d = mem_q;
    if (Wr_en) begin
      mem_d[Wr_addr] = Data_in;
    end
    dout_d = dout_q;
    if (Rd_en) begin
      dout_d = rd_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign Data_out = dout_q;

endmodule

// File: tb/tb_dual_port_memory.sv
// Scoreboard bench for dual_port_memory.
// Reads push expected words; they are popped and compared after the edge.
module tb_dual_port_memory;
  import dpm_pkg::*;

  logic  Clk;
  logic  Rst;
  logic  Wr_en;
  addr_t Wr_addr;
  word_t Data_in;
  logic  Rd_en;
  addr_t Rd_addr;
  word_t Data_out;

  int    total;
  int    bad;
  word_t model [DEPTH];
  word_t dout_m;
  word_t exp_q [$];

  dual_port_memory dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Wr_en    (Wr_en),
    .Wr_addr  (Wr_addr),
    .Data_in  (Data_in),
    .Rd_en    (Rd_en),
    .Rd_addr  (Rd_addr),
    .Data_out (Data_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    dout_m = '0;
    exp_q.delete();
  endtask

  task automatic cyc(input string tag,
                     input logic we, input addr_t wa, input word_t din,
                     input logic re, input addr_t ra);
    word_t e;
    @(negedge Clk);
    Wr_en   = we;
    Wr_addr = wa;
    Data_in = din;
    Rd_en   = re;
    Rd_addr = ra;
    if (re) begin
      e = (we && wa == ra) ? din : model[ra];
      exp_q.push_back(e);
    end
    @(posedge Clk);
    if (we) model[wa] = din;
    #1;
    if (re) begin
      e = exp_q.pop_front();
      dout_m = e;
      chk(tag, Data_out, e);
    end else begin
      chk(tag, Data_out, dout_m);
    end
  endtask

  word_t pat [4];

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    Wr_en = 1'b0; Wr_addr = '0; Data_in = '0;
    Rd_en = 1'b0; Rd_addr = '0;
    Rst   = 1'b1;
    #1 Rst = 1'b0;
    #10;
    chk("reset_dout", Data_out, '0);
    @(negedge Clk);
    Rst = 1'b1;

    for (int a = 0; a < DEPTH; a++)
      cyc("reset_rd", 1'b0, '0, '0, 1'b1, addr_t'(a));

    pat[0] = 32'hAAAAAAAA;
    pat[1] = 32'h55555554;
    pat[2] = 32'hFFFFFFFE;
    pat[3] = 32'hAAAAAAA8;
    for (int i = 0; i < 4; i++)
      cyc("wr", 1'b1, addr_t'(i + 1), pat[i], 1'b0, '0);
    for (int i = 0; i < 4; i++)
      cyc("readback", 1'b0, '0, '0, 1'b1, addr_t'(i + 1));

    cyc("hold_rd", 1'b0, '0, '0, 1'b1, 4'd3);
    for (int a = 0; a < 4; a++)
      cyc("hold", 1'b0, '0, '0, 1'b0, addr_t'(a * 5));
    chk("hold_val", Data_out, 32'hFFFFFFFE);

    cyc("coll_pre", 1'b1, 4'd5, 32'h11111111, 1'b0, '0);
    cyc("coll", 1'b1, 4'd5, 32'h22222222, 1'b1, 4'd5);
    chk("coll_new", Data_out, 32'h22222222);
    cyc("coll_post", 1'b0, '0, '0, 1'b1, 4'd5);

    cyc("conc", 1'b1, 4'd15, 32'hDEADBEEF, 1'b1, 4'd2);
    cyc("conc_post", 1'b0, '0, '0, 1'b1, 4'd15);
    chk("conc_val", Data_out, 32'hDEADBEEF);

    for (int i = 0; i < 3; i++)
      cyc("burst", 1'b1, addr_t'(6 + i), word_t'(32'hC0DE0000 + i),
          1'b1, addr_t'(15 - i));
    @(negedge Clk);
    Wr_en   = 1'b1;
    Wr_addr = 4'd9;
    Data_in = 32'h12345678;
    Rd_en   = 1'b1;
    Rd_addr = 4'd9;
    @(posedge Clk);
    #2 Rst = 1'b0;
    #1;
    chk("rst_async", Data_out, '0);
    model_clear();
    @(posedge Clk);
    #1;
    chk("rst_held", Data_out, '0);
    @(negedge Clk);
    Wr_en = 1'b0;
    Rd_en = 1'b0;
    Rst   = 1'b1;
    for (int a = 0; a < DEPTH; a++)
      cyc("post_rst_rd", 1'b0, '0, '0, 1'b1, addr_t'(a));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
